eth_udp_pkt_gen: RTL

Upstream neighbour of the Ethernet RMII transmit block. It builds the IPv4 + UDP portion of a frame (the Ethernet MAC payload) and writes it byte-by-byte into the transmit block's payload FIFO through Eth_Byte/Eth_Byte_Valid. It then pulses Eth_Pkt_Rdy to launch transmission. It computes the IPv4 header checksum, pulls user payload through a read-request interface, and zero-pads to the 46-byte Ethernet minimum.

---
 rtl/eth_udp_pkt_gen_pkg.sv | 32 +++
 rtl/eth_udp_pkt_gen_if.sv | 23 ++
 rtl/eth_udp_pkt_gen_csum.sv | 26 ++
 rtl/eth_udp_pkt_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/eth_udp_pkt_gen_pkg.sv
// Shared state encoding, IPv4/UDP header constants and padding helper for the
// UDP packet generator.
package eth_udp_pkt_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM,
    FOLD,
    HDR,
    PAYLOAD,
    PAD,
    DONE
  } state_t;

  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IPV4_PROTO_UDP = 8'h11;
  localparam logic [15:0] IPV4_FLAGS_DF  = 16'h4000;
  localparam int          IPV4_HDR_LEN   = 20;
  localparam int          UDP_HDR_LEN    = 8;
  localparam int          HDR_BYTES      = IPV4_HDR_LEN + UDP_HDR_LEN;
  localparam int          MIN_FRAME_PLD  = 46;
  localparam int          CSUM_WORDS     = IPV4_HDR_LEN / 2;
  localparam int          FOLD_CYCLES    = 2;

  // Zero bytes needed after the payload to reach the Ethernet minimum.
  function automatic logic [10:0] pad_bytes(input logic [10:0] n);
    if (n < 11'(MIN_FRAME_PLD - HDR_BYTES))
      return 11'(MIN_FRAME_PLD - HDR_BYTES) - n;
    return '0;
  endfunction

endpackage

// File: rtl/eth_udp_pkt_gen_if.sv
// Request, payload-pull and tx-FIFO write signals of the UDP packet generator.
interface eth_udp_pkt_gen_if;
  logic        Start;
  logic [10:0] Pld_Len;
  logic        Pld_Rd;
  logic [7:0]  Pld_Data;
  logic        Fifo_Afull;
  logic        Busy;
  logic        Len_Err;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Rdy;

  modport master (
    input  Start, Pld_Len, Pld_Data, Fifo_Afull,
    output Pld_Rd, Busy, Len_Err, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy
  );

  modport slave (
    output Start, Pld_Len, Pld_Data, Fifo_Afull,
    input  Pld_Rd, Busy, Len_Err, Eth_Byte, Eth_Byte_Valid, Eth_Pkt_Rdy
  );
endinterface

// File: rtl/eth_udp_pkt_gen_csum.sv
// IPv4 header checksum: 20-bit word accumulator with end-around-carry folding
// and ones'-complement result.
module ipv4_csum_acc (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        clr,
  input  logic        add,
  input  logic        fold,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc;

  always_ff @(posedge Clk) begin
    if (Rst || clr)
      acc <= '0;
    else if (add)
      acc <= acc + {4'd0, word};
    else if (fold)
      acc <= {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
  end

  assign csum = ~acc[15:0];

endmodule

// File: rtl/eth_udp_pkt_gen.sv
// Builds the IPv4 + UDP portion of an Ethernet frame and streams it byte by
// byte into the RMII transmit FIFO, padding to the 46-byte minimum.
module eth_udp_pkt_gen
  import eth_udp_pkt_gen_pkg::*;
#(
  parameter logic [31:0] pSRC_IP   = 32'hC0A80164,
  parameter logic [31:0] pDST_IP   = 32'hFFFFFFFF,
  parameter logic [15:0] pSRC_PORT = 16'd1234,
  parameter logic [15:0] pDST_PORT = 16'd5678,
  parameter logic [7:0]  pTTL      = 8'd64,
  parameter logic [10:0] pMAX_PLD  = 11'd1472
) (
  input logic               Clk,
  input logic               Rst,
  eth_udp_pkt_gen_if.master bus
);

  state_t      state;
  logic [4:0]  cnt;
  logic [10:0] len;
  logic [10:0] rem;
  logic [15:0] id;
  logic [7:0]  byte_q;
  logic        vld_p1;
  logic        fwd_p1;
  logic        busy_q;
  logic        len_err_q;
  logic        pkt_rdy_q;

  logic        accept;
  logic        pld_rd;
  logic [15:0] csum_word;
  logic [15:0] csum;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [0:HDR_BYTES-1][7:0] hdr;

  assign accept  = (state == IDLE) && bus.Start && (bus.Pld_Len <= pMAX_PLD);
  assign pld_rd  = (state == PAYLOAD) && !bus.Fifo_Afull && (rem != '0);
  assign tot_len = 16'(HDR_BYTES) + 16'(len);
  assign udp_len = 16'(UDP_HDR_LEN) + 16'(len);

  always_comb begin
    csum_word = '0;
    case (cnt)
      5'd0: csum_word = {IPV4_VER_IHL, 8'h00};
      5'd1: csum_word = tot_len;
      5'd2: csum_word = id;
      5'd3: csum_word = IPV4_FLAGS_DF;
      5'd4: csum_word = {pTTL, IPV4_PROTO_UDP};
      5'd6: csum_word = pSRC_IP[31:16];
      5'd7: csum_word = pSRC_IP[15:0];
      5'd8: csum_word = pDST_IP[31:16];
      5'd9: csum_word = pDST_IP[15:0];
      default: csum_word = '0;
    endcase
  end

  ipv4_csum_acc u_csum (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (accept),
    .add  (state == CSUM),
    .fold (state == FOLD),
    .word (csum_word),
    .csum (csum)
  );

  assign hdr = {IPV4_VER_IHL, 8'h00, tot_len, id, IPV4_FLAGS_DF, pTTL,
                IPV4_PROTO_UDP, csum, pSRC_IP, pDST_IP,
                pSRC_PORT, pDST_PORT, udp_len, 16'h0000};

  always_ff @(posedge Clk) begin
    if (accept)
      len <= bus.Pld_Len;
  end

  // Issue stage: at most one byte decided per cycle, written to the FIFO next cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      id        <= '0;
      byte_q    <= '0;
      vld_p1    <= 1'b0;
      fwd_p1    <= 1'b0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      pkt_rdy_q <= 1'b0;
    end else begin
      vld_p1    <= 1'b0;
      fwd_p1    <= pld_rd;
      len_err_q <= 1'b0;
      pkt_rdy_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            if (accept) begin
              busy_q <= 1'b1;
              cnt    <= '0;
              state  <= CSUM;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        CSUM: begin
          if (cnt == 5'(CSUM_WORDS - 1)) begin
            cnt   <= '0;
            state <= FOLD;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        FOLD: begin
          if (cnt == 5'(FOLD_CYCLES - 1)) begin
            cnt   <= '0;
            state <= HDR;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        HDR: begin
          if (!bus.Fifo_Afull) begin
            byte_q <= hdr[cnt];
            vld_p1 <= 1'b1;
            if (cnt == 5'(HDR_BYTES - 1)) begin
              cnt <= '0;
              if (len != '0) begin
                rem   <= len;
                state <= PAYLOAD;
              end else begin
                rem   <= pad_bytes(len);
                state <= PAD;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        PAYLOAD: begin
          if (pld_rd) begin
            vld_p1 <= 1'b1;
            if (rem == 11'd1) begin
              rem   <= pad_bytes(len);
              state <= PAD;
            end else begin
              rem <= rem - 11'd1;
            end
          end
        end
        PAD: begin
          // rem==0 here is the cycle the final byte is being written
          if (rem == '0) begin
            pkt_rdy_q <= 1'b1;
            id        <= id + 16'd1;
            state     <= DONE;
          end else if (!bus.Fifo_Afull) begin
            byte_q <= '0;
            vld_p1 <= 1'b1;
            rem    <= rem - 11'd1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write stage: payload bytes pass straight from the source to the FIFO
  assign bus.Pld_Rd         = pld_rd;
  assign bus.Eth_Byte       = fwd_p1 ? bus.Pld_Data : byte_q;
  assign bus.Eth_Byte_Valid = vld_p1;
  assign bus.Busy           = busy_q;
  assign bus.Len_Err        = len_err_q;
  assign bus.Eth_Pkt_Rdy    = pkt_rdy_q;

endmodule
